coreapb3_iaddr_arb: RTL
=======================

Name: coreapb3_iaddr_arb

Overview:
- APB3 master that shares the indirect-address window between two requesters.
- Each granted request is sequenced in two phases: first the 32-bit target address is programmed into the indirect address register at IADDR_BASE, then one data access is made at WINDOW_BASE.
- Sits between two internal bus clients and a CoreAPB3 slave slot. Arbitration is round-robin.

Parameters:
- APB_DWIDTH, 32, APB data width. Legal values are 8, 16, 32. The address phase takes 32/APB_DWIDTH beats.
- IADDR_BASE, 32'h0000_0000, APB address of the indirect address register. Beat k is written at IADDR_BASE+4k.
- WINDOW_BASE, 32'h0000_0100, APB address of the indirect data window.

Ports:
- PCLK  in  1  clock
- PRESETN  in  1  asynchronous active-low reset
- REQ0, REQ1  in  1 each  request, held high until the matching DONE
- ADDR0, ADDR1  in  32 each  target address, stable while REQ is high
- WR0, WR1  in  1 each  1=write, 0=read
- WDATA0, WDATA1  in  32 each  write data; low APB_DWIDTH bits used
- DONE0, DONE1  out  1 each  one-cycle completion pulse
- RDATA  out  32  read data, zero-extended from APB_DWIDTH
- ERR  out  1  error flag for the last completed request, valid with DONE
- PSEL, PENABLE, PWRITE  out  1 each  APB master controls
- PADDR  out  32  APB address
- PWDATA  out  32  APB write data
- PRDATA  in  32  APB read data
- PREADY, PSLVERR  in  1 each  APB completion and error

Behaviour:
- Reset is PRESETN, asynchronous, active-low; clock is PCLK. All outputs are registered.
- Reset values: all outputs 0; state IDLE; round-robin pointer last=1, so requester 0 wins the first tie.
- State machine: IDLE, ISETUP, IACCESS, DSETUP, DACCESS, RESP.
- IDLE:
  - REQn is sampled only in IDLE.
  - One requester high: grant it. Both high: grant the one that is not `last`.
  - On grant: latch addr, wr and wdata; set last=granted; beat=0; go to ISETUP.
- ISETUP:
  - PSEL=1, PENABLE=0, PWRITE=1, PADDR=IADDR_BASE+4*beat.
  - PWDATA = latched address slice [beat*APB_DWIDTH +: APB_DWIDTH], upper bits 0.
  - Next state IACCESS.
- IACCESS:
  - PENABLE=1. Wait states last while PREADY=0; PADDR, PWRITE and PWDATA stay stable.
  - On PREADY=1 with PSLVERR=1: set ERR=1, skip the data phase, go to RESP.
  - On PREADY=1 with PSLVERR=0: if this was the last beat go to DSETUP, else beat+1 and go to ISETUP.
- DSETUP:
  - PSEL=1, PENABLE=0, PADDR=WINDOW_BASE, PWRITE=latched wr.
  - PWDATA = latched wdata, masked to APB_DWIDTH.
- DACCESS:
  - PENABLE=1. Completes on PREADY=1; ERR=PSLVERR.
  - On a read, RDATA is captured from PRDATA[APB_DWIDTH-1:0], even when PSLVERR=1.
  - RDATA holds its value until the next read completes.
- RESP:
  - DONEn=1 for the granted requester, for one cycle only. Next state IDLE.
  - PSEL=0 in RESP and IDLE.
- Requester rule: REQn must be low in the cycle after DONEn; otherwise it is taken as a new request.
- Latency from REQ sampled in IDLE (cycle 0), PREADY=1, no cache hit:
  - DONE at cycle 1 + 2*(32/APB_DWIDTH) + 2, i.e. cycle 5 at 32-bit and cycle 11 at 8-bit.
  - Each PREADY=0 cycle adds one cycle.
- A request that rises mid-transaction waits, and is served next if the other requester has just been served.
- Reset mid-transaction: PSEL and PENABLE drop immediately; no DONE is issued for the aborted request.

Optional Feature:
- Macro: COREAPB3_IADDR_CACHE_EN.
- Defined:
  - A 32-bit cache register plus a valid bit hold the last address fully written into the indirect register.
  - On grant, if valid and the address equals the cache, go straight to DSETUP.
  - The cache is updated when the last address beat completes without error.
  - valid=0 on reset and on any PSLVERR during the address phase.
  - A cache hit completes with DONE at cycle 3.
- Undefined: the address phase always runs; no cache logic exists.

Test Plan:
- APB_DWIDTH=32, PREADY=1. REQ0 write, ADDR0=32'h4000_1234, WDATA0=32'hDEAD_BEEF. Expect APB write 0x0000_0000←0x4000_1234, then write 0x0000_0100←0xDEADBEEF; DONE0 at cycle 5; ERR=0.
- APB_DWIDTH=8, read of 32'hA1B2_C3D4, slave returns PRDATA=0x5A. Expect address beats 0xD4, 0xC3, 0xB2, 0xA1 at 0x0, 0x4, 0x8, 0xC; then read at 0x100; RDATA=0x0000_005A; DONE at cycle 11.
- REQ0 and REQ1 rise together and stay asserted for four back-to-back requests. Expect grant order 0,1,0,1 and DONE pulses alternating.
- PSLVERR=1 on the first address beat. Expect no data-window access; DONE with ERR=1. With the cache enabled, the next request to the same address re-runs the address phase.
- PREADY=0 for 3 cycles during DACCESS. Expect PADDR and PWDATA stable through the wait; DONE delayed by 3 cycles. PRESETN low mid-IACCESS gives PSEL=0 asynchronously and no DONE.
- COREAPB3_IADDR_CACHE_EN defined: two writes to 32'h4000_0010. Expect the second write skips the address phase and gives DONE at cycle 3; a third request to 32'h4000_0014 runs the full address phase.

Source files
------------

// File: rtl/coreapb3_iaddr_arb.sv
// Two-requester APB3 master that shares an indirect-address window using round-robin arbitration.
// The optional last-address cache is enabled by defining COREAPB3_IADDR_CACHE_EN.
module coreapb3_iaddr_arb #(
    parameter int unsigned APB_DWIDTH  = 32,
    parameter logic [31:0] IADDR_BASE  = 32'h0000_0000,
    parameter logic [31:0] WINDOW_BASE = 32'h0000_0100
) (
    input  logic        PCLK,
    input  logic        PRESETN,
    input  logic        REQ0,
    input  logic        REQ1,
    input  logic [31:0] ADDR0,
    input  logic [31:0] ADDR1,
    input  logic        WR0,
    input  logic        WR1,
    input  logic [31:0] WDATA0,
    input  logic [31:0] WDATA1,
    output logic        DONE0,
    output logic        DONE1,
    output logic [31:0] RDATA,
    output logic        ERR,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);
    localparam int unsigned NBEATS    = 32 / APB_DWIDTH;
    localparam logic [1:0]  LAST_BEAT = 2'(NBEATS - 1);
    localparam logic [31:0] DMASK     = (APB_DWIDTH == 32) ? 32'hFFFF_FFFF
                                        : ((32'd1 << APB_DWIDTH) - 32'd1);

    typedef enum logic [2:0] {
        S_IDLE, S_ISETUP, S_IACCESS, S_DSETUP, S_DACCESS, S_RESP
    } state_t;

    state_t      r_state, w_state_next;
    logic [1:0]  r_beat, w_beat_next;
    logic [31:0] r_addr, w_addr_next;
    logic [31:0] r_wdata, w_wdata_next;
    logic        r_wr, w_wr_next;
    logic        r_gnt, w_gnt_next;
    logic        r_last, w_last_next;
    logic        w_err_next, w_done_next;
    logic        w_psel_next, w_penable_next, w_pwrite_next;
    logic [31:0] w_paddr_next, w_pwdata_next, w_rdata_next;
    logic [31:0] w_shamt;
    logic        w_sel;
    logic [31:0] w_sel_addr;
    logic        w_cache_hit;

    // Tie goes to whoever was not served last; a lone request wins outright.
    assign w_sel      = (REQ0 && REQ1) ? ~r_last : ~REQ0;
    assign w_sel_addr = w_sel ? ADDR1 : ADDR0;

`ifdef COREAPB3_IADDR_CACHE_EN
    logic [31:0] r_cache;
    logic        r_cache_valid;

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_cache       <= 32'd0;
            r_cache_valid <= 1'b0;
        end else if (r_state == S_IACCESS && PREADY) begin
            if (PSLVERR) begin
                r_cache_valid <= 1'b0;
            end else if (r_beat == LAST_BEAT) begin
                r_cache       <= r_addr;
                r_cache_valid <= 1'b1;
            end
        end
    end

    assign w_cache_hit = r_cache_valid && (w_sel_addr == r_cache);
`else
    assign w_cache_hit = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_beat_next  = r_beat;
        w_addr_next  = r_addr;
        w_wdata_next = r_wdata;
        w_wr_next    = r_wr;
        w_gnt_next   = r_gnt;
        w_last_next  = r_last;
        w_err_next   = ERR;
        w_rdata_next = RDATA;
        case (r_state)
            S_IDLE: begin
                if (REQ0 || REQ1) begin
                    w_gnt_next   = w_sel;
                    w_last_next  = w_sel;
                    w_addr_next  = w_sel_addr;
                    w_wr_next    = w_sel ? WR1 : WR0;
                    w_wdata_next = w_sel ? WDATA1 : WDATA0;
                    w_beat_next  = 2'd0;
                    w_state_next = w_cache_hit ? S_DSETUP : S_ISETUP;
                end
            end
            S_ISETUP: w_state_next = S_IACCESS;
            S_IACCESS: begin
                if (PREADY) begin
                    if (PSLVERR) begin
                        w_err_next   = 1'b1;
                        w_state_next = S_RESP;
                    end else if (r_beat == LAST_BEAT) begin
                        w_state_next = S_DSETUP;
                    end else begin
                        w_beat_next  = r_beat + 2'd1;
                        w_state_next = S_ISETUP;
                    end
                end
            end
            S_DSETUP: w_state_next = S_DACCESS;
            S_DACCESS: begin
                if (PREADY) begin
                    w_err_next = PSLVERR;
                    if (!r_wr) begin
                        w_rdata_next = PRDATA & DMASK;
                    end
                    w_state_next = S_RESP;
                end
            end
            S_RESP:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // APB outputs are registered, so they are derived from the state being entered.
    assign w_shamt = 32'(w_beat_next) * APB_DWIDTH;

    always_comb begin
        w_psel_next    = 1'b0;
        w_penable_next = 1'b0;
        w_pwrite_next  = PWRITE;
        w_paddr_next   = PADDR;
        w_pwdata_next  = PWDATA;
        w_done_next    = (w_state_next == S_RESP);
        case (w_state_next)
            S_ISETUP: begin
                w_psel_next   = 1'b1;
                w_pwrite_next = 1'b1;
                w_paddr_next  = IADDR_BASE + {28'd0, w_beat_next, 2'b00};
                w_pwdata_next = (w_addr_next >> w_shamt) & DMASK;
            end
            S_IACCESS: begin
                w_psel_next    = 1'b1;
                w_penable_next = 1'b1;
            end
            S_DSETUP: begin
                w_psel_next   = 1'b1;
                w_pwrite_next = w_wr_next;
                w_paddr_next  = WINDOW_BASE;
                w_pwdata_next = w_wdata_next & DMASK;
            end
            S_DACCESS: begin
                w_psel_next    = 1'b1;
                w_penable_next = 1'b1;
            end
            default: begin
                w_psel_next    = 1'b0;
                w_penable_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_state <= S_IDLE;
            r_beat  <= 2'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_wr    <= 1'b0;
            r_gnt   <= 1'b0;
            r_last  <= 1'b1;
            ERR     <= 1'b0;
            RDATA   <= 32'd0;
            DONE0   <= 1'b0;
            DONE1   <= 1'b0;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= 32'd0;
            PWDATA  <= 32'd0;
        end else begin
            r_state <= w_state_next;
            r_beat  <= w_beat_next;
            r_addr  <= w_addr_next;
            r_wdata <= w_wdata_next;
            r_wr    <= w_wr_next;
            r_gnt   <= w_gnt_next;
            r_last  <= w_last_next;
            ERR     <= w_err_next;
            RDATA   <= w_rdata_next;
            DONE0   <= w_done_next && !w_gnt_next;
            DONE1   <= w_done_next && w_gnt_next;
            PSEL    <= w_psel_next;
            PENABLE <= w_penable_next;
            PWRITE  <= w_pwrite_next;
            PADDR   <= w_paddr_next;
            PWDATA  <= w_pwdata_next;
        end
    end
endmodule
